// File: rtl/branch_predictor_if.sv
// Prediction/resolution handshake between fetch/execute (master) and the
// conditional-jump predictor (slave).
interface branch_predictor_if #(
  parameter int DEPTH = 2
);
  localparam int OUT_W = $clog2(DEPTH) + 1;

  logic             pred_req;
  logic [10:0]      pred_pc;
  logic [10:0]      pred_target;
  logic [10:0]      pred_fall;
  logic             pred_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic [10:0]      pred_next;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             flush;
  logic [10:0]      flush_pc;
  logic             resolve_err;
  logic [OUT_W-1:0] outstanding;

  modport master (
    output pred_req, pred_pc, pred_target, pred_fall, resolve_valid, resolve_taken,
    input  pred_ready, pred_valid, pred_taken, pred_next, flush, flush_pc,
           resolve_err, outstanding
  );

  modport slave (
    input  pred_req, pred_pc, pred_target, pred_fall, resolve_valid, resolve_taken,
    output pred_ready, pred_valid, pred_taken, pred_next, flush, flush_pc,
           resolve_err, outstanding
  );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter branch predictor with an in-order FIFO of
// unresolved guesses; a wrong guess trains the table and flushes.
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  logic [1:0]       r_ctr       [ENTRIES];
  logic [IDX_W-1:0] r_fifo_idx  [DEPTH];
  logic             r_fifo_guess[DEPTH];
  logic [10:0]      r_fifo_alt  [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             r_pred_valid;
  logic             r_pred_taken;
  logic [10:0]      r_pred_next;
  logic             r_flush;
  logic [10:0]      r_flush_pc;
  logic             r_resolve_err;

  logic             w_ready;
  logic             w_accept;
  logic [IDX_W-1:0] w_lookup_idx;
  logic             w_guess;
  logic             w_empty;
  logic             w_resolve;
  logic             w_err;
  logic [IDX_W-1:0] w_head_idx;
  logic             w_head_guess;
  logic [10:0]      w_head_alt;
  logic             w_mispredict;
  logic             w_push;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_upd;

  // Ready depends only on current occupancy, so a same-cycle pop cannot
  // combinationally admit a request into a full FIFO.
  assign w_ready      = (r_count != CNT_W'(DEPTH));
  assign w_accept     = bp.pred_req && w_ready;
  assign w_lookup_idx = bp.pred_pc[IDX_W-1:0];
  assign w_guess      = r_ctr[w_lookup_idx][1];

  assign w_empty      = (r_count == '0);
  assign w_resolve    = bp.resolve_valid && !w_empty;
  assign w_err        = bp.resolve_valid && w_empty;
  assign w_head_idx   = r_fifo_idx[r_rd_ptr];
  assign w_head_guess = r_fifo_guess[r_rd_ptr];
  assign w_head_alt   = r_fifo_alt[r_rd_ptr];
  assign w_mispredict = w_resolve && (bp.resolve_taken != w_head_guess);
  assign w_push       = w_accept && !w_mispredict;
  assign w_ctr_cur    = r_ctr[w_head_idx];

  always_comb begin
    w_ctr_upd = w_ctr_cur;
    if (bp.resolve_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_upd = w_ctr_cur + 2'b01;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_upd = w_ctr_cur - 2'b01;
    end
  end

  // Lookup reads the pre-update value, since the table write lands on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
    end else if (w_resolve) begin
      r_ctr[w_head_idx] <= w_ctr_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_idx[r_wr_ptr]   <= w_lookup_idx;
      r_fifo_guess[r_wr_ptr] <= w_guess;
      r_fifo_alt[r_wr_ptr]   <= w_guess ? bp.pred_fall : bp.pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_mispredict) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_resolve) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_resolve})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_next   <= '0;
      r_flush       <= 1'b0;
      r_flush_pc    <= '0;
      r_resolve_err <= 1'b0;
    end else begin
      r_pred_valid  <= w_push;
      r_flush       <= w_mispredict;
      r_resolve_err <= w_err;
      if (w_push) begin
        r_pred_taken <= w_guess;
        r_pred_next  <= w_guess ? bp.pred_target : bp.pred_fall;
      end
      if (w_mispredict) r_flush_pc <= w_head_alt;
    end
  end

  assign bp.pred_ready  = w_ready;
  assign bp.pred_valid  = r_pred_valid;
  assign bp.pred_taken  = r_pred_taken;
  assign bp.pred_next   = r_pred_next;
  assign bp.flush       = r_flush;
  assign bp.flush_pc    = r_flush_pc;
  assign bp.resolve_err = r_resolve_err;
  assign bp.outstanding = r_count;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomised checks of branch_predictor against a queue-based
// reference model with a prediction scoreboard.
module tb_branch_predictor;
  logic clk;
  logic rst_n;
  int   chk_pass;
  int   chk_total;

  branch_predictor_if #(.DEPTH(2)) bp_if ();

  branch_predictor #(.IDX_W(4), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  idx;
    logic        guess;
    logic [10:0] alt;
  } ent_t;

  typedef struct packed {
    logic        taken;
    logic [10:0] next;
  } pred_t;

  logic [1:0]  m_ctr [16];
  ent_t        m_fifo[$];
  pred_t       exp_q[$];
  logic        e_valid;
  logic        e_flush;
  logic        e_err;
  logic [10:0] e_flush_pc;
  int          e_out;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 2'b01;
    m_fifo.delete();
    exp_q.delete();
  endtask

  task automatic clear_inputs();
    bp_if.pred_req      = 1'b0;
    bp_if.pred_pc       = '0;
    bp_if.pred_target   = '0;
    bp_if.pred_fall     = '0;
    bp_if.resolve_valid = 1'b0;
    bp_if.resolve_taken = 1'b0;
  endtask

  // Drives one cycle, advances the reference model and queues the expected prediction.
  task automatic step(input logic req, input logic [10:0] pc, input logic [10:0] tgt,
                      input logic [10:0] fall, input logic rv, input logic rt);
    logic acc;
    logic g;
    ent_t h;
    bp_if.pred_req      = req;
    bp_if.pred_pc       = pc;
    bp_if.pred_target   = tgt;
    bp_if.pred_fall     = fall;
    bp_if.resolve_valid = rv;
    bp_if.resolve_taken = rt;
    acc     = req && (m_fifo.size() < 2);
    g       = m_ctr[pc[3:0]][1];
    e_flush = 1'b0;
    e_err   = 1'b0;
    if (rv) begin
      if (m_fifo.size() == 0) begin
        e_err = 1'b1;
      end else begin
        h = m_fifo.pop_front();
        if (rt && m_ctr[h.idx] != 2'b11) m_ctr[h.idx] = m_ctr[h.idx] + 2'b01;
        else if (!rt && m_ctr[h.idx] != 2'b00) m_ctr[h.idx] = m_ctr[h.idx] - 2'b01;
        if (rt != h.guess) begin
          e_flush    = 1'b1;
          e_flush_pc = h.alt;
          m_fifo.delete();
        end
      end
    end
    e_valid = acc && !e_flush;
    if (e_valid) begin
      m_fifo.push_back('{pc[3:0], g, (g ? fall : tgt)});
      exp_q.push_back('{g, (g ? tgt : fall)});
    end
    e_out = m_fifo.size();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    chk_total++; if (bp_if.outstanding !== 2'd0) $display("FAIL reset_outstanding got %0d want 0", bp_if.outstanding); else chk_pass++;
    chk_total++; if (bp_if.pred_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", bp_if.pred_ready); else chk_pass++;
    chk_total++; if (bp_if.pred_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", bp_if.pred_valid); else chk_pass++;
    chk_total++; if (bp_if.pred_taken !== 1'b0) $display("FAIL reset_taken got %0b want 0", bp_if.pred_taken); else chk_pass++;
    chk_total++; if (bp_if.flush !== 1'b0) $display("FAIL reset_flush got %0b want 0", bp_if.flush); else chk_pass++;
    chk_total++; if (bp_if.resolve_err !== 1'b0) $display("FAIL reset_err got %0b want 0", bp_if.resolve_err); else chk_pass++;
    chk_total++; if (bp_if.pred_next !== 11'h000) $display("FAIL reset_next got %h want 000", bp_if.pred_next); else chk_pass++;
    chk_total++; if (bp_if.flush_pc !== 11'h000) $display("FAIL reset_flush_pc got %h want 000", bp_if.flush_pc); else chk_pass++;
  endtask

  task automatic test_lookup();
    step(1'b1, 11'h013, 11'h200, 11'h014, 1'b0, 1'b0);
    chk_total++; if (bp_if.pred_valid !== 1'b1) $display("FAIL lookup_valid got %0b want 1", bp_if.pred_valid); else chk_pass++;
    chk_total++; if (bp_if.pred_taken !== 1'b0) $display("FAIL lookup_taken got %0b want 0", bp_if.pred_taken); else chk_pass++;
    chk_total++; if (bp_if.pred_next !== 11'h014) $display("FAIL lookup_next got %h want 014", bp_if.pred_next); else chk_pass++;
    chk_total++; if (bp_if.outstanding !== 2'd1) $display("FAIL lookup_outstanding got %0d want 1", bp_if.outstanding); else chk_pass++;
    step(1'b0, 11'h000, 11'h000, 11'h000, 1'b0, 1'b0);
    chk_total++; if (bp_if.pred_valid !== 1'b0) $display("FAIL lookup_pulse got %0b want 0", bp_if.pred_valid); else chk_pass++;
  endtask

  task automatic test_train();
    step(1'b0, 11'h000, 11'h000, 11'h000, 1'b1, 1'b1);
    chk_total++; if (bp_if.flush !== 1'b1) $display("FAIL train_flush got %0b want 1", bp_if.flush); else chk_pass++;
    chk_total++; if (bp_if.flush_pc !== 11'h200) $display("FAIL train_flush_pc got %h want 200", bp_if.flush_pc); else chk_pass++;
    chk_total++; if (bp_if.outstanding !== 2'd0) $display("FAIL train_outstanding got %0d want 0", bp_if.outstanding); else chk_pass++;
    step(1'b1, 11'h013, 11'h200, 11'h014, 1'b0, 1'b0);
    chk_total++; if (bp_if.flush !== 1'b0) $display("FAIL train_flush_pulse got %0b want 0", bp_if.flush); else chk_pass++;
    chk_total++; if (bp_if.pred_taken !== 1'b1) $display("FAIL train_taken2 got %0b want 1", bp_if.pred_taken); else chk_pass++;
    chk_total++; if (bp_if.pred_next !== 11'h200) $display("FAIL train_next2 got %h want 200", bp_if.pred_next); else chk_pass++;
    step(1'b0, 11'h000, 11'h000, 11'h000, 1'b1, 1'b1);
    chk_total++; if (bp_if.flush !== 1'b0) $display("FAIL train_match_flush got %0b want 0", bp_if.flush); else chk_pass++;
    step(1'b1, 11'h013, 11'h200, 11'h014, 1'b0, 1'b0);
    chk_total++; if (bp_if.pred_next !== 11'h200) $display("FAIL train_next3 got %h want 200", bp_if.pred_next); else chk_pass++;
    // Counter is 11 here; a further taken resolve must stay saturated at 11.
    step(1'b0, 11'h000, 11'h000, 11'h000, 1'b1, 1'b1);
    step(1'b1, 11'h013, 11'h200, 11'h014, 1'b0, 1'b0);
    chk_total++; if (bp_if.pred_taken !== 1'b1) $display("FAIL train_clamp got %0b want 1", bp_if.pred_taken); else chk_pass++;
    step(1'b0, 11'h000, 11'h000, 11'h000, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    step(1'b1, 11'h030, 11'h100, 11'h031, 1'b0, 1'b0);
    step(1'b1, 11'h031, 11'h110, 11'h032, 1'b0, 1'b0);
    chk_total++; if (bp_if.outstanding !== 2'd2) $display("FAIL bp_full_count got %0d want 2", bp_if.outstanding); else chk_pass++;
    chk_total++; if (bp_if.pred_ready !== 1'b0) $display("FAIL bp_full_ready got %0b want 0", bp_if.pred_ready); else chk_pass++;
    step(1'b1, 11'h032, 11'h120, 11'h033, 1'b0, 1'b0);
    chk_total++; if (bp_if.pred_valid !== 1'b0) $display("FAIL bp_ignored_valid got %0b want 0", bp_if.pred_valid); else chk_pass++;
    step(1'b1, 11'h032, 11'h120, 11'h033, 1'b1, 1'b0);
    chk_total++; if (bp_if.pred_valid !== 1'b0) $display("FAIL bp_pop_valid got %0b want 0", bp_if.pred_valid); else chk_pass++;
    chk_total++; if (bp_if.outstanding !== 2'd1) $display("FAIL bp_pop_count got %0d want 1", bp_if.outstanding); else chk_pass++;
    chk_total++; if (bp_if.pred_ready !== 1'b1) $display("FAIL bp_pop_ready got %0b want 1", bp_if.pred_ready); else chk_pass++;
    step(1'b1, 11'h032, 11'h120, 11'h033, 1'b0, 1'b0);
    chk_total++; if (bp_if.pred_valid !== 1'b1) $display("FAIL bp_retry_valid got %0b want 1", bp_if.pred_valid); else chk_pass++;
    chk_total++; if (bp_if.pred_next !== 11'h033) $display("FAIL bp_retry_next got %h want 033", bp_if.pred_next); else chk_pass++;
    step(1'b0, 11'h000, 11'h000, 11'h000, 1'b1, 1'b0);
    step(1'b0, 11'h000, 11'h000, 11'h000, 1'b1, 1'b0);
    chk_total++; if (bp_if.outstanding !== 2'd0) $display("FAIL bp_drain_count got %0d want 0", bp_if.outstanding); else chk_pass++;
  endtask

  task automatic test_squash();
    step(1'b1, 11'h021, 11'h150, 11'h022, 1'b0, 1'b0);
    step(1'b1, 11'h022, 11'h160, 11'h023, 1'b0, 1'b0);
    step(1'b1, 11'h040, 11'h170, 11'h041, 1'b1, 1'b1);
    chk_total++; if (bp_if.flush !== 1'b1) $display("FAIL squash_flush got %0b want 1", bp_if.flush); else chk_pass++;
    chk_total++; if (bp_if.flush_pc !== 11'h150) $display("FAIL squash_flush_pc got %h want 150", bp_if.flush_pc); else chk_pass++;
    chk_total++; if (bp_if.outstanding !== 2'd0) $display("FAIL squash_count got %0d want 0", bp_if.outstanding); else chk_pass++;
    chk_total++; if (bp_if.pred_valid !== 1'b0) $display("FAIL squash_valid got %0b want 0", bp_if.pred_valid); else chk_pass++;
    step(1'b0, 11'h000, 11'h000, 11'h000, 1'b0, 1'b0);
    chk_total++; if (bp_if.flush !== 1'b0) $display("FAIL squash_pulse got %0b want 0", bp_if.flush); else chk_pass++;
  endtask

  task automatic test_empty_resolve();
    step(1'b0, 11'h000, 11'h000, 11'h000, 1'b1, 1'b1);
    chk_total++; if (bp_if.resolve_err !== 1'b1) $display("FAIL empty_err got %0b want 1", bp_if.resolve_err); else chk_pass++;
    chk_total++; if (bp_if.flush !== 1'b0) $display("FAIL empty_flush got %0b want 0", bp_if.flush); else chk_pass++;
    chk_total++; if (bp_if.outstanding !== 2'd0) $display("FAIL empty_count got %0d want 0", bp_if.outstanding); else chk_pass++;
    step(1'b1, 11'h00A, 11'h300, 11'h00B, 1'b0, 1'b0);
    chk_total++; if (bp_if.resolve_err !== 1'b0) $display("FAIL empty_err_pulse got %0b want 0", bp_if.resolve_err); else chk_pass++;
    chk_total++; if (bp_if.pred_taken !== 1'b0) $display("FAIL empty_table_taken got %0b want 0", bp_if.pred_taken); else chk_pass++;
    step(1'b0, 11'h000, 11'h000, 11'h000, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    pred_t       p;
    logic [10:0] pc;
    exp_q.delete();
    for (int n = 0; n < 120; n++) begin
      pc      = 11'($urandom);
      pc[3:0] = 4'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), pc, 11'($urandom), 11'($urandom),
           ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      chk_total++; if (bp_if.pred_valid !== e_valid) $display("FAIL rnd_valid cyc %0d got %0b want %0b", n, bp_if.pred_valid, e_valid); else chk_pass++;
      if (bp_if.pred_valid === 1'b1 && exp_q.size() > 0) begin
        p = exp_q.pop_front();
        chk_total++; if ({bp_if.pred_taken, bp_if.pred_next} !== {p.taken, p.next}) $display("FAIL rnd_pred cyc %0d got %0b/%h want %0b/%h", n, bp_if.pred_taken, bp_if.pred_next, p.taken, p.next); else chk_pass++;
      end
      chk_total++; if (bp_if.flush !== e_flush) $display("FAIL rnd_flush cyc %0d got %0b want %0b", n, bp_if.flush, e_flush); else chk_pass++;
      if (e_flush) begin
        chk_total++; if (bp_if.flush_pc !== e_flush_pc) $display("FAIL rnd_flush_pc cyc %0d got %h want %h", n, bp_if.flush_pc, e_flush_pc); else chk_pass++;
      end
      chk_total++; if (bp_if.resolve_err !== e_err) $display("FAIL rnd_err cyc %0d got %0b want %0b", n, bp_if.resolve_err, e_err); else chk_pass++;
      chk_total++; if (bp_if.outstanding !== 2'(e_out)) $display("FAIL rnd_count cyc %0d got %0d want %0d", n, bp_if.outstanding, e_out); else chk_pass++;
    end
    chk_total++; if (exp_q.size() != 0) $display("FAIL rnd_scoreboard_left got %0d want 0", exp_q.size()); else chk_pass++;
  endtask

  task automatic test_async_reset();
    while (bp_if.outstanding != 2'd0) step(1'b0, 11'h000, 11'h000, 11'h000, 1'b1, 1'b0);
    step(1'b1, 11'h050, 11'h400, 11'h051, 1'b0, 1'b0);
    step(1'b1, 11'h051, 11'h410, 11'h052, 1'b0, 1'b0);
    chk_total++; if (bp_if.outstanding !== 2'd2) $display("FAIL areset_pre_count got %0d want 2", bp_if.outstanding); else chk_pass++;
    #2 rst_n = 1'b0;
    #1;
    chk_total++; if (bp_if.outstanding !== 2'd0) $display("FAIL areset_count got %0d want 0", bp_if.outstanding); else chk_pass++;
    chk_total++; if (bp_if.pred_valid !== 1'b0) $display("FAIL areset_valid got %0b want 0", bp_if.pred_valid); else chk_pass++;
    chk_total++; if (bp_if.pred_ready !== 1'b1) $display("FAIL areset_ready got %0b want 1", bp_if.pred_ready); else chk_pass++;
    chk_total++; if (bp_if.flush !== 1'b0) $display("FAIL areset_flush got %0b want 0", bp_if.flush); else chk_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 11'h000, 11'h000, 11'h000, 1'b0, 1'b0);
    chk_total++; if (bp_if.flush !== 1'b0) $display("FAIL areset_no_flush got %0b want 0", bp_if.flush); else chk_pass++;
    step(1'b1, 11'h013, 11'h200, 11'h014, 1'b0, 1'b0);
    chk_total++; if (bp_if.pred_taken !== 1'b0) $display("FAIL areset_table_taken got %0b want 0", bp_if.pred_taken); else chk_pass++;
    chk_total++; if (bp_if.pred_next !== 11'h014) $display("FAIL areset_table_next got %h want 014", bp_if.pred_next); else chk_pass++;
  endtask

  initial begin
    chk_pass  = 0;
    chk_total = 0;
    rst_n     = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_lookup();
    test_train();
    test_backpressure();
    test_squash();
    test_empty_resolve();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end
endmodule
